// File: rtl/riscv_main_control.sv
// riscv_main_control
// Combinational main control unit for a single-cycle RV32I core. Decodes the
// opcode (inst[6:0]) together with the funct3/funct7 fields supplied by the
// datapath into register-file, memory, immediate, ALU and PC-select controls.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset; no state is held,
//                 so neither affects the outputs.
//   inst        : current instruction; only the opcode field is decoded.
//   funct3      : instruction funct3 field (inst[14:12]).
//   funct7      : instruction funct7 field (inst[31:25]); only bit 5 is used.
//   Zero        : ALU result-is-zero flag, used for BEQ/BNE resolution.
//   RegWrite_E  : register-file write enable.
//   ImmSrc      : immediate format (I/S/B/U/J).
//   ALUSrc      : ALU operand B select (0 = rs2, 1 = immediate).
//   MemWrite_E  : data-memory write enable.
//   ResultSrc   : writeback select (ALU / memory / PC+4 / immediate).
//   PCSrc       : next-PC select (0 = PC+4, 1 = PC+immediate).
//   ALUControl  : ALU operation code.
module riscv_main_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        Zero,
   output logic        RegWrite_E,
   output logic [2:0]  ImmSrc,
   output logic        ALUSrc,
   output logic        MemWrite_E,
   output logic [1:0]  ResultSrc,
   output logic        PCSrc,
   output logic [3:0]  ALUControl
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_NONE = 4'b1111;

   logic [6:0] opcode;
   logic [3:0] alu_i;
   logic [3:0] alu_r;

   // Inputs kept only for interface uniformity.
   logic unused_inputs;
   assign unused_inputs = ^{clk, rst, inst[31:7], funct7[6], funct7[4:0]};

   assign opcode = inst[6:0];

   // Immediate-class ALU decode; funct7[5] only distinguishes SRAI from SRLI.
   always_comb begin
      alu_i = ALU_ADD;
      unique case (funct3)
         3'b000: alu_i = ALU_ADD;
         3'b001: alu_i = ALU_SLL;
         3'b010: alu_i = ALU_SLT;
         3'b011: alu_i = ALU_SLTU;
         3'b100: alu_i = ALU_XOR;
         3'b101: alu_i = funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110: alu_i = ALU_OR;
         3'b111: alu_i = ALU_AND;
         default: alu_i = ALU_ADD;
      endcase
   end

   // Register class adds SUB on funct3=000; ADDI has no such variant.
   assign alu_r = ((funct3 == 3'b000) && funct7[5]) ? ALU_SUB : alu_i;

   always_comb begin
      RegWrite_E = 1'b0;
      ImmSrc     = IMM_I;
      ALUSrc     = 1'b0;
      MemWrite_E = 1'b0;
      ResultSrc  = RES_ALU;
      PCSrc      = 1'b0;
      ALUControl = alu_i;
      case (opcode)
         OP_R: begin
            RegWrite_E = 1'b1;
            ALUControl = alu_r;
         end
         OP_I_ALU: begin
            RegWrite_E = 1'b1;
            ALUSrc     = 1'b1;
         end
         OP_LOAD: begin
            RegWrite_E = 1'b1;
            ALUSrc     = 1'b1;
            ResultSrc  = RES_MEM;
            ALUControl = ALU_ADD;
         end
         OP_STORE: begin
            ImmSrc     = IMM_S;
            ALUSrc     = 1'b1;
            MemWrite_E = 1'b1;
            ResultSrc  = RES_MEM;
            ALUControl = ALU_ADD;
         end
         OP_BRANCH: begin
            ImmSrc     = IMM_B;
            ALUControl = ALU_XOR;
            // XOR result is zero exactly when the operands are equal.
            if (funct3 == 3'b000) begin
               PCSrc = Zero;
            end else if (funct3 == 3'b001) begin
               PCSrc = ~Zero;
            end
         end
         OP_JAL: begin
            RegWrite_E = 1'b1;
            ImmSrc     = IMM_J;
            ALUSrc     = 1'b1;
            ResultSrc  = RES_PC4;
            PCSrc      = 1'b1;
            ALUControl = ALU_NONE;
         end
         OP_LUI: begin
            RegWrite_E = 1'b1;
            ImmSrc     = IMM_U;
            ALUSrc     = 1'b1;
            ResultSrc  = RES_IMM;
            ALUControl = ALU_NONE;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_riscv_main_control.sv
// Self-checking bench for riscv_main_control: directed steps from the test
// plan followed by randomized instructions, all checked against a table-driven
// reference model of the decode rules.
module tb_riscv_main_control;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        Zero;
   logic        RegWrite_E;
   logic [2:0]  ImmSrc;
   logic        ALUSrc;
   logic        MemWrite_E;
   logic [1:0]  ResultSrc;
   logic        PCSrc;
   logic [3:0]  ALUControl;

   int compared   = 0;
   int mismatched = 0;

   riscv_main_control dut (
      .clk        (clk),
      .rst        (rst),
      .inst       (inst),
      .funct3     (funct3),
      .funct7     (funct7),
      .Zero       (Zero),
      .RegWrite_E (RegWrite_E),
      .ImmSrc     (ImmSrc),
      .ALUSrc     (ALUSrc),
      .MemWrite_E (MemWrite_E),
      .ResultSrc  (ResultSrc),
      .PCSrc      (PCSrc),
      .ALUControl (ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU kinds used by the decode table.
   localparam int K_R = 0, K_I = 1, K_ADD = 2, K_XOR = 3, K_NONE = 4;

   typedef struct {
      logic [6:0] op;
      int         regw;
      int         imm;
      int         alusrc;
      int         memw;
      int         res;
      int         kind;
   } row_t;

   row_t tab [7];
   // ALU code for each funct3 in the immediate class (before SRA/SUB variants).
   int   f3_alu [8];

   initial begin
      tab[0] = '{7'b0110011, 1, 0, 0, 0, 0, K_R};
      tab[1] = '{7'b0010011, 1, 0, 1, 0, 0, K_I};
      tab[2] = '{7'b0000011, 1, 0, 1, 0, 1, K_ADD};
      tab[3] = '{7'b0100011, 0, 1, 1, 1, 1, K_ADD};
      tab[4] = '{7'b1100011, 0, 2, 0, 0, 0, K_XOR};
      tab[5] = '{7'b1101111, 1, 4, 1, 0, 2, K_NONE};
      tab[6] = '{7'b0110111, 1, 3, 1, 0, 3, K_NONE};
      f3_alu = '{0, 5, 8, 9, 4, 6, 3, 2};
   end

   int exp_regw, exp_imm, exp_alusrc, exp_memw, exp_res, exp_pc, exp_alu;

   task automatic model(input logic [31:0] i, input logic z);
      row_t r;
      int   f3;
      int   f7b5;
      r    = '{7'd0, 0, 0, 0, 0, 0, K_I};
      for (int k = 0; k < 7; k++) begin
         if (tab[k].op == i[6:0]) r = tab[k];
      end
      f3   = int'(i[14:12]);
      f7b5 = int'(i[30]);
      exp_regw   = r.regw;
      exp_imm    = r.imm;
      exp_alusrc = r.alusrc;
      exp_memw   = r.memw;
      exp_res    = r.res;
      case (r.kind)
         K_ADD:   exp_alu = 0;
         K_XOR:   exp_alu = 4;
         K_NONE:  exp_alu = 15;
         default: begin
            exp_alu = f3_alu[f3];
            if (f3 == 5 && f7b5 == 1) exp_alu = 7;
            if (r.kind == K_R && f3 == 0 && f7b5 == 1) exp_alu = 1;
         end
      endcase
      exp_pc = 0;
      if (i[6:0] == 7'b1101111) exp_pc = 1;
      if (i[6:0] == 7'b1100011) begin
         if (f3 == 0) exp_pc = int'(z);
         if (f3 == 1) exp_pc = 1 - int'(z);
      end
   endtask

   task automatic check(input string tag, input string field, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      model(inst, Zero);
      check(tag, "RegWrite_E", int'(RegWrite_E), exp_regw);
      check(tag, "ImmSrc",     int'(ImmSrc),     exp_imm);
      check(tag, "ALUSrc",     int'(ALUSrc),     exp_alusrc);
      check(tag, "MemWrite_E", int'(MemWrite_E), exp_memw);
      check(tag, "ResultSrc",  int'(ResultSrc),  exp_res);
      check(tag, "PCSrc",      int'(PCSrc),      exp_pc);
      check(tag, "ALUControl", int'(ALUControl), exp_alu);
   endtask

   // Drive an instruction with funct fields consistent with its encoding.
   task automatic drive(input logic [31:0] i, input logic z);
      inst   = i;
      funct3 = i[14:12];
      funct7 = i[31:25];
      Zero   = z;
   endtask

   task automatic step(input string tag, input logic [31:0] i, input logic z);
      @(negedge clk);
      drive(i, z);
      #1;
      check_all(tag);
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
      logic [31:0] rnd;
      rnd = $urandom;
      return {f7, rnd[24:15], f3, rnd[11:7], op};
   endfunction

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011;

   initial begin
      logic [6:0] ops [8];
      logic [31:0] rnd;
      rst = 1'b1;
      drive(32'h0000_0013, 1'b0);
      // Reset active: outputs still follow the instruction.
      step("rst_addi", mk(7'h00, 3'b000, I), 1'b0);
      step("rst_beq",  mk(7'h00, 3'b000, BR), 1'b1);
      rst = 1'b0;

      step("r_add",  mk(7'b0000000, 3'b000, R), 1'b0);
      step("r_sub",  mk(7'b0100000, 3'b000, R), 1'b0);
      step("r_xor",  mk(7'b0000000, 3'b100, R), 1'b0);
      step("r_or",   mk(7'b0000000, 3'b110, R), 1'b0);
      step("r_and",  mk(7'b0000000, 3'b111, R), 1'b0);
      step("r_sra",  mk(7'b0100000, 3'b101, R), 1'b0);
      step("r_srl",  mk(7'b0000000, 3'b101, R), 1'b0);
      step("r_slt",  mk(7'b0000000, 3'b010, R), 1'b0);
      step("r_sltu", mk(7'b0000000, 3'b011, R), 1'b0);
      step("r_sll",  mk(7'b0000000, 3'b001, R), 1'b0);
      step("r_f7ff", mk(7'b1111111, 3'b111, R), 1'b0);

      step("addi",      mk(7'b0000000, 3'b000, I), 1'b0);
      step("addi_f7b5", mk(7'b0100000, 3'b000, I), 1'b0);
      step("xori",      mk(7'b0000000, 3'b100, I), 1'b0);
      step("slli",      mk(7'b0000000, 3'b001, I), 1'b0);
      step("slti",      mk(7'b0000000, 3'b010, I), 1'b0);
      step("srai",      mk(7'b0100000, 3'b101, I), 1'b0);
      step("lw",        mk(7'b0000000, 3'b010, LD), 1'b0);
      step("sw",        mk(7'b0000000, 3'b010, ST), 1'b0);

      step("beq_z1", mk(7'b0000000, 3'b000, BR), 1'b1);
      Zero = 1'b0;
      #1;
      check_all("beq_z0");
      step("bne_z0", mk(7'b0000000, 3'b001, BR), 1'b0);
      step("bne_z1", mk(7'b0000000, 3'b001, BR), 1'b1);
      step("blt_z1", mk(7'b0000000, 3'b100, BR), 1'b1);

      step("jal", 32'h1234_506F, 1'b0);
      step("lui", 32'hABCD_E0B7, 1'b1);
      step("illegal", mk(7'b0000000, 3'b000, 7'b1111111), 1'b1);

      // ADD then ADDI inside one clock phase.
      @(negedge clk);
      drive(mk(7'b0000000, 3'b000, R), 1'b0);
      #1;
      check_all("b2b_add");
      drive(mk(7'b0000000, 3'b000, I), 1'b0);
      #1;
      check_all("b2b_addi");

      ops = '{R, I, LD, ST, BR, 7'b1101111, 7'b0110111, 7'b0};
      for (int n = 0; n < 300; n++) begin
         rnd = $urandom;
         rst = rnd[31];
         if (rnd[2:0] == 3'd7) begin
            step("rand", $urandom, rnd[3]);
         end else begin
            step("rand", {rnd[30:7], 1'b0, ops[rnd[2:0]]}, rnd[3]);
            inst[7] = rnd[4];
            #1;
            check_all("rand_b7");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
